// File: rtl/gpio_in_conditioner.sv
// GPIO input front end: 2-flop sync, per-bit debounce, parity append, change pulse.
// Optional sticky rising-edge interrupt when GPIOCOND_IRQ_EN is defined.
module gpio_in_conditioner #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH-1:0] PIN,
  input  logic             PARITYSEL,
`ifdef GPIOCOND_IRQ_EN
  input  logic [WIDTH-1:0] IRQMASK,
  input  logic             IRQCLR,
  output logic             IRQ,
`endif
  output logic [WIDTH:0]   GPIOIN,
  output logic             CHANGE
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] w_db_next;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic             r_change;

  // Any return to equality restarts the count.
  always_comb begin
    w_db_next = r_db;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (r_s2[i] != r_db[i]) begin
        if (r_cnt[i] == CMAX) begin
          w_db_next[i] = r_s2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_db     <= '0;
      r_change <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1     <= PIN;
      r_s2     <= r_s1;
      r_db     <= w_db_next;
      r_change <= |(w_db_next ^ r_db);
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign GPIOIN = {(^r_db) ^ PARITYSEL, r_db};
  assign CHANGE = r_change;

`ifdef GPIOCOND_IRQ_EN
  logic w_irq_set;
  logic r_irq;

  assign w_irq_set = |(IRQMASK & w_db_next & ~r_db);

  // A new rising event wins over a simultaneous clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (IRQCLR) begin
      r_irq <= 1'b0;
    end
  end

  assign IRQ = r_irq;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: directed cases plus random pins
// against a window-based behavioural model.
module tb_gpio_in_conditioner;
  localparam int W  = 16;
  localparam int DB = 4;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [W-1:0] PIN = '0;
  logic         PARITYSEL = 1'b0;
  logic [W:0]   GPIOIN;
  logic         CHANGE;
`ifdef GPIOCOND_IRQ_EN
  logic [W-1:0] IRQMASK = '0;
  logic         IRQCLR = 1'b0;
  logic         IRQ;
`endif

  gpio_in_conditioner #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PIN       (PIN),
    .PARITYSEL (PARITYSEL),
`ifdef GPIOCOND_IRQ_EN
    .IRQMASK   (IRQMASK),
    .IRQCLR    (IRQCLR),
    .IRQ       (IRQ),
`endif
    .GPIOIN    (GPIOIN),
    .CHANGE    (CHANGE)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: every PIN value sampled since reset, indexed by edge number.
  // A bit flips at edge n when the synchronised values of the last DB edges
  // all disagree with it and it has not flipped inside that window.
  logic [W-1:0] m_hist[$];
  int           m_n;
  int           m_last[W];
  logic [W-1:0] m_db;
  logic         m_chg;
  logic         m_irq;

  function automatic logic [W-1:0] s2_at(int j);
    if (j - 2 < 0) return '0;
    return m_hist[j-2];
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_n   = 0;
    m_db  = '0;
    m_chg = 1'b0;
    m_irq = 1'b0;
    for (int i = 0; i < W; i++) m_last[i] = -1000;
  endtask

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      model_reset();
    end else begin
      logic [W-1:0] nd;
      logic [W-1:0] v;
      logic         all;
      m_hist.push_back(PIN);
      nd = m_db;
      for (int i = 0; i < W; i++) begin
        if (m_last[i] <= m_n - DB) begin
          all = 1'b1;
          for (int j = m_n - DB + 1; j <= m_n; j++) begin
            v = s2_at(j);
            if (v[i] == m_db[i]) all = 1'b0;
          end
          if (all) begin
            nd[i]     = ~m_db[i];
            m_last[i] = m_n;
          end
        end
      end
      m_chg = (nd != m_db);
`ifdef GPIOCOND_IRQ_EN
      if ((IRQMASK & nd & ~m_db) != '0) m_irq = 1'b1;
      else if (IRQCLR) m_irq = 1'b0;
`endif
      m_db = nd;
      m_n++;
    end
  end

  always @(posedge HCLK) begin
    #1;
    chk("gpioin", 32'(GPIOIN), 32'({(^m_db) ^ PARITYSEL, m_db}));
    chk("change", 32'(CHANGE), 32'(m_chg));
`ifdef GPIOCOND_IRQ_EN
    chk("irq", 32'(IRQ), 32'(m_irq));
`endif
  end

  task automatic settle();
    @(negedge HCLK);
    PIN = '0;
    PARITYSEL = 1'b0;
    repeat (10) @(negedge HCLK);
  endtask

  initial begin
    int pulses;
    int b;
    model_reset();
    PIN = 16'hFFFF;
    #1 chk("rst_gpioin", 32'(GPIOIN), 32'h0);
    PARITYSEL = 1'b1;
    #1 chk("rst_par", 32'(GPIOIN[W]), 32'h1);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    settle();

    // Latency and parity
    PIN = 16'h00A5;
    @(posedge HCLK);
    for (int e = 1; e <= 5; e++) begin
      @(posedge HCLK);
      #2;
      if (e == 4) chk("lat_pre", 32'({CHANGE, GPIOIN}), 32'h0);
    end
    chk("lat_data", 32'(GPIOIN[W-1:0]), 32'h00A5);
    chk("lat_par0", 32'(GPIOIN[W]), 32'h0);
    chk("lat_chg", 32'(CHANGE), 32'h1);
    PARITYSEL = 1'b1;
    #1 chk("lat_par1", 32'(GPIOIN[W]), 32'h1);
    @(posedge HCLK);
    #2 chk("lat_chg_end", 32'(CHANGE), 32'h0);
    settle();

    // Glitch of three samples
    PIN[0] = 1'b1;
    repeat (3) @(negedge HCLK);
    PIN[0] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge HCLK);
      #2 chk("glitch", 32'({CHANGE, GPIOIN}), 32'h0);
    end
    settle();

    // Bounce 1,0,1 then hold
    PIN[3] = 1'b1;
    @(negedge HCLK) PIN[3] = 1'b0;
    @(negedge HCLK) PIN[3] = 1'b1;
    pulses = 0;
    for (int e = 0; e <= 12; e++) begin
      @(posedge HCLK);
      #2;
      pulses += int'(CHANGE);
      if (e == 4) chk("bounce_pre", 32'(GPIOIN[3]), 32'h0);
      if (e == 5) chk("bounce_at", 32'(GPIOIN[3]), 32'h1);
    end
    chk("bounce_pulses", 32'(pulses), 32'h1);
    settle();

    // Reset mid-count
    PIN = 16'h8000;
    @(posedge HCLK);
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b0;
    #1 chk("rstmid_out", 32'({CHANGE, GPIOIN}), 32'h0);
    @(negedge HCLK) HRESETn = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      @(posedge HCLK);
      #2;
      if (e == 4) chk("rstmid_pre", 32'(GPIOIN[15]), 32'h0);
      if (e == 5) chk("rstmid_at", 32'(GPIOIN[15]), 32'h1);
    end
    settle();

`ifdef GPIOCOND_IRQ_EN
    IRQMASK = 16'h0001;
    PIN[0] = 1'b1;
    @(posedge HCLK);
    repeat (5) @(posedge HCLK);
    #2 chk("irq_set", 32'(IRQ), 32'h1);
    @(negedge HCLK) IRQCLR = 1'b1;
    @(negedge HCLK) IRQCLR = 1'b0;
    chk("irq_clr1", 32'(IRQ), 32'h0);
    PIN[1] = 1'b1;
    repeat (8) @(negedge HCLK);
    chk("irq_masked", 32'(IRQ), 32'h0);
    PIN[0] = 1'b0;
    repeat (8) @(negedge HCLK);
    PIN[0] = 1'b1;
    repeat (5) @(negedge HCLK);
    IRQCLR = 1'b1;
    @(negedge HCLK) IRQCLR = 1'b0;
    chk("irq_set_wins", 32'(IRQ), 32'h1);
    IRQCLR = 1'b1;
    @(negedge HCLK) IRQCLR = 1'b0;
    chk("irq_clr2", 32'(IRQ), 32'h0);
    settle();
`endif

    // Random pins, parity, clears and occasional resets
    for (int c = 0; c < 2000; c++) begin
      @(negedge HCLK);
      if ($urandom_range(0, 2) == 0) begin
        b = int'($urandom_range(0, W - 1));
        PIN[b] = ~PIN[b];
      end
      if ($urandom_range(0, 9) == 0) PIN = PIN ^ W'($urandom);
      if ($urandom_range(0, 15) == 0) PARITYSEL = ~PARITYSEL;
`ifdef GPIOCOND_IRQ_EN
      IRQCLR = ($urandom_range(0, 7) == 0);
      if (c % 400 == 0) IRQMASK = W'($urandom);
`endif
      if ($urandom_range(0, 499) == 0) begin
        HRESETn = 1'b0;
        #2 HRESETn = 1'b1;
      end
    end
    repeat (3) @(negedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
